// File: rtl/enemy_bullet_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : enemy_bullet_ctrl
// Purpose  : Single-bullet enemy projectile engine. Spawns a bullet under the
//            enemy column after a tick-based cooldown, moves it down one row
//            per game tick, and retires it when it is hit or leaves the field.
// Ports    : i_Clk, i_Rst (async, active-high)  - clock / reset
//            i_Enable                           - game running (low = pause)
//            i_Enemy_x[2:0]                     - enemy column, sampled at spawn
//            i_fCollision                       - collision flag (level)
//            Enemy_Bullet_x[2:0]                - bullet column (0 when parked)
//            Enemy_Bullet_y[4:0]                - bullet row    (0 when parked)
//            o_Bullet_Valid                     - bullet in flight
//            o_Tick                             - one-clock game tick strobe
//            o_Spawn / o_Expire / o_Hit         - one-clock event pulses
// Revision : 1.0 - initial release
// ============================================================================
module enemy_bullet_ctrl #(
    parameter int unsigned TICK_CNT    = 800_000,
    parameter int unsigned Y_START     = 1,
    parameter int unsigned Y_MAX       = 31,
    parameter int unsigned SPAWN_TICKS = 8
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_Enable,
    input  logic [2:0] i_Enemy_x,
    input  logic       i_fCollision,
    output logic [2:0] Enemy_Bullet_x,
    output logic [4:0] Enemy_Bullet_y,
    output logic       o_Bullet_Valid,
    output logic       o_Tick,
    output logic       o_Spawn,
    output logic       o_Expire,
    output logic       o_Hit
);

    localparam logic [19:0] c_tick_max = 20'(TICK_CNT);
    localparam logic [4:0]  c_y_start  = 5'(Y_START);
    localparam logic [4:0]  c_y_max    = 5'(Y_MAX);
    localparam logic [7:0]  c_cooldown = 8'(SPAWN_TICKS);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_FLY  = 1'b1
    } state_t;

    logic [19:0] tick_cnt_q, tick_cnt_d;
    state_t      state_q,    state_d;
    logic [7:0]  cool_q,     cool_d;
    logic [2:0]  x_q,        x_d;
    logic [4:0]  y_q,        y_d;
    logic        valid_q,    valid_d;
    logic        spawn_q,    spawn_d;
    logic        expire_q,   expire_d;
    logic        hit_q,      hit_d;

    logic        w_tick;

    // Free-running tick divider; keeps counting while paused so the tick
    // stays phase-aligned with the collision stage.
    assign w_tick = (tick_cnt_q == c_tick_max);

    always_comb begin
        tick_cnt_d = w_tick ? 20'd0 : tick_cnt_q + 20'd1;

        state_d    = state_q;
        cool_d     = cool_q;
        x_d        = x_q;
        y_d        = y_q;
        valid_d    = valid_q;
        spawn_d    = 1'b0;
        expire_d   = 1'b0;
        hit_d      = 1'b0;

        if (w_tick && i_Enable) begin
            case (state_q)
                ST_IDLE: begin
                    if (cool_q != 8'd0) begin
                        cool_d = cool_q - 8'd1;
                    end else begin
                        x_d     = i_Enemy_x;
                        y_d     = c_y_start;
                        valid_d = 1'b1;
                        spawn_d = 1'b1;
                        state_d = ST_FLY;
                    end
                end
                ST_FLY: begin
                    // Collision outranks reaching the last row so a hit on
                    // the final row is still reported as a hit.
                    if (i_fCollision || (y_q == c_y_max)) begin
                        state_d  = ST_IDLE;
                        cool_d   = c_cooldown;
                        x_d      = 3'd0;
                        y_d      = 5'd0;
                        valid_d  = 1'b0;
                        expire_d = 1'b1;
                        hit_d    = i_fCollision;
                    end else begin
                        y_d = y_q + 5'd1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            tick_cnt_q <= 20'd0;
            state_q    <= ST_IDLE;
            cool_q     <= c_cooldown;
            x_q        <= 3'd0;
            y_q        <= 5'd0;
            valid_q    <= 1'b0;
            spawn_q    <= 1'b0;
            expire_q   <= 1'b0;
            hit_q      <= 1'b0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            state_q    <= state_d;
            cool_q     <= cool_d;
            x_q        <= x_d;
            y_q        <= y_d;
            valid_q    <= valid_d;
            spawn_q    <= spawn_d;
            expire_q   <= expire_d;
            hit_q      <= hit_d;
        end
    end

    assign Enemy_Bullet_x = x_q;
    assign Enemy_Bullet_y = y_q;
    assign o_Bullet_Valid = valid_q;
    assign o_Tick         = w_tick;
    assign o_Spawn        = spawn_q;
    assign o_Expire       = expire_q;
    assign o_Hit          = hit_q;

endmodule
`default_nettype wire

// File: tb/tb_enemy_bullet_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_enemy_bullet_ctrl
// Purpose  : Self-checking bench for enemy_bullet_ctrl with a short tick
//            period. A behavioural model tracks the game rules per clock and
//            is compared against the DUT on every falling edge; directed
//            scenarios add literal expectations at key points.
// Revision : 1.0 - initial release
// ============================================================================
module tb_enemy_bullet_ctrl;

    localparam int TICK_CNT    = 3;
    localparam int Y_START     = 1;
    localparam int Y_MAX       = 4;
    localparam int SPAWN_TICKS = 2;
    localparam int PERIOD      = TICK_CNT + 1;

    logic       clk;
    logic       rst;
    logic       en;
    logic [2:0] ex;
    logic       col;
    logic [2:0] bx;
    logic [4:0] by;
    logic       valid, tick, spawn, expire, hit;

    int n_checks = 0;
    int n_err    = 0;

    enemy_bullet_ctrl #(
        .TICK_CNT    (TICK_CNT),
        .Y_START     (Y_START),
        .Y_MAX       (Y_MAX),
        .SPAWN_TICKS (SPAWN_TICKS)
    ) dut (
        .i_Clk          (clk),
        .i_Rst          (rst),
        .i_Enable       (en),
        .i_Enemy_x      (ex),
        .i_fCollision   (col),
        .Enemy_Bullet_x (bx),
        .Enemy_Bullet_y (by),
        .o_Bullet_Valid (valid),
        .o_Tick         (tick),
        .o_Spawn        (spawn),
        .o_Expire       (expire),
        .o_Hit          (hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Behavioural model: clocks since reset give the tick phase; game
    // state is a flying flag, remaining cooldown ticks and a position.
    // ------------------------------------------------------------------
    int m_clocks;
    bit m_fly;
    int m_cd;
    int m_x, m_y;
    bit m_spawn, m_expire, m_hit;
    bit m_tick_now;

    assign m_tick_now = ((m_clocks % PERIOD) == TICK_CNT);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_clocks <= 0;
            m_fly    <= 1'b0;
            m_cd     <= SPAWN_TICKS;
            m_x      <= 0;
            m_y      <= 0;
            m_spawn  <= 1'b0;
            m_expire <= 1'b0;
            m_hit    <= 1'b0;
        end else begin
            m_clocks <= m_clocks + 1;
            m_spawn  <= 1'b0;
            m_expire <= 1'b0;
            m_hit    <= 1'b0;
            if (m_tick_now && en) begin
                if (!m_fly) begin
                    if (m_cd > 0) begin
                        m_cd <= m_cd - 1;
                    end else begin
                        m_fly   <= 1'b1;
                        m_x     <= int'(ex);
                        m_y     <= Y_START;
                        m_spawn <= 1'b1;
                    end
                end else if (col || m_y == Y_MAX) begin
                    m_fly    <= 1'b0;
                    m_cd     <= SPAWN_TICKS;
                    m_x      <= 0;
                    m_y      <= 0;
                    m_expire <= 1'b1;
                    m_hit    <= col;
                end else begin
                    m_y <= m_y + 1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always begin
        @(negedge clk);
        chk("cyc_x",      {29'd0, bx},     32'(m_x));
        chk("cyc_y",      {27'd0, by},     32'(m_y));
        chk("cyc_valid",  {31'd0, valid},  {31'd0, m_fly});
        chk("cyc_tick",   {31'd0, tick},   {31'd0, m_tick_now});
        chk("cyc_spawn",  {31'd0, spawn},  {31'd0, m_spawn});
        chk("cyc_expire", {31'd0, expire}, {31'd0, m_expire});
        chk("cyc_hit",    {31'd0, hit},    {31'd0, m_hit});
    end

    // Wait for the next tick edge; return 2 time units after it, with the
    // number of falling edges inspected before the tick was seen.
    task automatic next_tick(output int waited);
        waited = 0;
        repeat (2 * PERIOD) begin
            @(negedge clk);
            waited++;
            if (tick === 1'b1) begin
                @(posedge clk);
                #2;
                return;
            end
        end
        n_checks++;
        n_err++;
        $display("FAIL tick_timeout at %0t: got no tick expected one within %0d clocks", $time, 2 * PERIOD);
    endtask

    int w;

    initial begin
        rst = 1'b1;
        en  = 1'b1;
        ex  = 3'd5;
        col = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_y",     {27'd0, by},    32'd0);
        chk("rst_spawn", {31'd0, spawn}, 32'd0);
        rst = 1'b0;

        // Initial cooldown then spawn at x=5, y=1.
        next_tick(w); chk("cd1_valid", {31'd0, valid}, 32'd0);
        next_tick(w); chk("cd2_spawn", {31'd0, spawn}, 32'd0);
        next_tick(w);
        chk("sp1_spawn", {31'd0, spawn}, 32'd1);
        chk("sp1_x",     {29'd0, bx},    32'd5);
        chk("sp1_y",     {27'd0, by},    32'd1);
        chk("sp1_valid", {31'd0, valid}, 32'd1);

        // Free flight; enemy column changes mid-flight must not matter.
        ex = 3'd2;
        for (int yy = 2; yy <= 4; yy++) begin
            next_tick(w);
            chk("fly_y", {27'd0, by}, 32'(yy));
            chk("fly_x", {29'd0, bx}, 32'd5);
        end
        next_tick(w);
        chk("exp_expire", {31'd0, expire}, 32'd1);
        chk("exp_hit",    {31'd0, hit},    32'd0);
        chk("exp_valid",  {31'd0, valid},  32'd0);
        chk("exp_xy",     {24'd0, bx, by}, 32'd0);
        next_tick(w); chk("re_cd1", {31'd0, valid}, 32'd0);
        next_tick(w); chk("re_cd2", {31'd0, spawn}, 32'd0);
        next_tick(w);
        chk("re_spawn", {31'd0, spawn}, 32'd1);
        chk("re_x",     {29'd0, bx},    32'd2);

        // Collision at y=2.
        next_tick(w); chk("hit_pre_y", {27'd0, by}, 32'd2);
        col = 1'b1;
        next_tick(w);
        chk("hit_expire", {31'd0, expire}, 32'd1);
        chk("hit_hit",    {31'd0, hit},    32'd1);
        chk("hit_valid",  {31'd0, valid},  32'd0);
        col = 1'b0;
        next_tick(w);
        next_tick(w); chk("hit_cd_valid", {31'd0, valid}, 32'd0);
        next_tick(w); chk("hit_respawn",  {31'd0, spawn}, 32'd1);

        // Pause at y=3 for five ticks.
        next_tick(w);
        next_tick(w); chk("pz_pre_y", {27'd0, by}, 32'd3);
        en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            next_tick(w);
            chk("pz_y",      {27'd0, by},    32'd3);
            chk("pz_period", 32'(w),         32'd4);
            chk("pz_valid",  {31'd0, valid}, 32'd1);
        end
        en = 1'b1;
        next_tick(w); chk("pz_resume_y", {27'd0, by}, 32'd4);

        // Collision on the last row wins over expiry.
        col = 1'b1;
        next_tick(w);
        chk("pri_expire", {31'd0, expire}, 32'd1);
        chk("pri_hit",    {31'd0, hit},    32'd1);
        col = 1'b0;

        // Respawn, fly to y=3, then reset between edges.
        next_tick(w);
        next_tick(w);
        next_tick(w); chk("ar_spawn", {31'd0, spawn}, 32'd1);
        next_tick(w);
        next_tick(w); chk("ar_pre_y", {27'd0, by}, 32'd3);
        #1;
        rst = 1'b1;
        #1;
        chk("ar_valid", {31'd0, valid}, 32'd0);
        chk("ar_xy",    {24'd0, bx, by}, 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        next_tick(w); chk("ar_t1", {31'd0, spawn}, 32'd0);
        next_tick(w); chk("ar_t2", {31'd0, spawn}, 32'd0);
        next_tick(w);
        chk("ar_t3_spawn", {31'd0, spawn}, 32'd1);
        chk("ar_t3_y",     {27'd0, by},    32'd1);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
